// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice readout blocks.
// Contents:
//   seq_state_t    - sequencer state encoding
//   DICE_NONE      - "no dice visible" pip value
//   DICE_MAX       - highest legal pip value
//   sanitise_pips  - maps illegal reader codes (7) to DICE_NONE
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MOTION,
        SETTLE,
        DONE,
        ERROR
    } seq_state_t;

    localparam logic [2:0] DICE_NONE = 3'd0;
    localparam logic [2:0] DICE_MAX  = 3'd6;

    // The reader can emit 7 on a corrupted frame; treat it as "nothing seen".
    function automatic logic [2:0] sanitise_pips(input logic [2:0] pips);
        return (pips > DICE_MAX) ? DICE_NONE : pips;
    endfunction

endpackage

// File: rtl/dice_roll_sequencer_vsync_tick.sv
// Frame tick generator: one-pclk pulse on each falling edge of vsync.
// Ports:
//   pclk       in  pixel clock
//   reset      in  synchronous, active-high
//   vsync      in  frame sync level, synchronous to pclk
//   frame_tick out high for one cycle after vsync goes 1 -> 0
module vsync_tick (
    input  logic pclk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    // Resets low so a vsync held high out of reset gives no tick until it falls.
    logic vsync_q;

    always_ff @(posedge pclk) begin
        if (reset) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign frame_tick = vsync_q & ~vsync;

endmodule

// File: rtl/dice_roll_sequencer.sv
// Dice roll sequencer: arms on start, waits for visible motion, then accepts
// a pip value once it has been identical and non-zero for STABLE_FRAMES
// consecutive frames. The result is offered with a valid/ack handshake; if
// no result settles within TIMEOUT_FRAMES frames an error is raised instead.
// Ports:
//   pclk          in  pixel clock
//   reset         in  synchronous, active-high
//   vsync         in  frame sync level
//   dice_value    in  [2:0] reader output (0 none, 1..6 pips, 7 treated as 0)
//   start         in  request a roll readout (only honoured in IDLE)
//   ack           in  consumer acknowledge of result or error
//   busy          out high whenever not IDLE
//   result        out [2:0] last accepted pip value
//   result_valid  out high in DONE
//   timeout_err   out high in ERROR
//   frames_waited out [7:0] frame ticks since arm, saturating at 255
module dice_roll_sequencer
    import dice_pkg::*;
#(
    parameter int STABLE_FRAMES  = 8,
    parameter int TIMEOUT_FRAMES = 240,
    parameter int REQUIRE_MOTION = 1
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [2:0] dice_value,
    input  logic       start,
    input  logic       ack,
    output logic       busy,
    output logic [2:0] result,
    output logic       result_valid,
    output logic       timeout_err,
    output logic [7:0] frames_waited
);

    localparam logic [3:0] STABLE_C  = 4'(STABLE_FRAMES);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_FRAMES);

    logic       frame_tick;
    logic [2:0] sample;

    seq_state_t state_q, state_d;
    logic [2:0] arm_val_q, arm_val_d;
    logic [2:0] last_val_q, last_val_d;
    logic [3:0] stable_cnt_q, stable_cnt_d;
    logic [7:0] frames_q, frames_d;
    logic [7:0] frames_inc;
    logic [2:0] result_q, result_d;
    logic       busy_q, valid_q, err_q;

    vsync_tick u_vsync_tick (
        .pclk       (pclk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    assign sample     = sanitise_pips(dice_value);
    assign frames_inc = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        arm_val_d    = arm_val_q;
        last_val_d   = last_val_q;
        stable_cnt_d = stable_cnt_q;
        frames_d     = frames_q;
        result_d     = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    arm_val_d    = sample;
                    last_val_d   = DICE_NONE;
                    stable_cnt_d = 4'd0;
                    frames_d     = 8'd0;
                    state_d      = (REQUIRE_MOTION != 0) ? WAIT_MOTION : SETTLE;
                end
            end
            WAIT_MOTION: begin
                if (frame_tick) begin
                    frames_d = frames_inc;
                    // The motion frame itself seeds the stability run.
                    if (sample != arm_val_q || sample == DICE_NONE) begin
                        state_d      = SETTLE;
                        last_val_d   = sample;
                        stable_cnt_d = (sample != DICE_NONE) ? 4'd1 : 4'd0;
                    end
                    if (frames_inc == TIMEOUT_C) begin
                        state_d = ERROR;
                    end
                end
            end
            SETTLE: begin
                if (frame_tick) begin
                    frames_d = frames_inc;
                    if (sample == DICE_NONE) begin
                        stable_cnt_d = 4'd0;
                    end else if (sample == last_val_q) begin
                        stable_cnt_d = stable_cnt_q + 4'd1;
                    end else begin
                        last_val_d   = sample;
                        stable_cnt_d = 4'd1;
                    end
                    // Settling takes priority over a coincident timeout.
                    if (stable_cnt_d == STABLE_C) begin
                        result_d = sample;
                        state_d  = DONE;
                    end else if (frames_inc == TIMEOUT_C) begin
                        state_d = ERROR;
                    end
                end
            end
            DONE, ERROR: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q      <= IDLE;
            arm_val_q    <= DICE_NONE;
            last_val_q   <= DICE_NONE;
            stable_cnt_q <= 4'd0;
            frames_q     <= 8'd0;
            result_q     <= DICE_NONE;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            arm_val_q    <= arm_val_d;
            last_val_q   <= last_val_d;
            stable_cnt_q <= stable_cnt_d;
            frames_q     <= frames_d;
            result_q     <= result_d;
            // Status flags are registered from the next state so they line up with it.
            busy_q       <= (state_d != IDLE);
            valid_q      <= (state_d == DONE);
            err_q        <= (state_d == ERROR);
        end
    end

    assign busy          = busy_q;
    assign result        = result_q;
    assign result_valid  = valid_q;
    assign timeout_err   = err_q;
    assign frames_waited = frames_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
module tb_dice_roll_sequencer;

    localparam int STABLE = 8;
    localparam int TMO    = 240;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic [2:0] dice_value = 3'd0;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic       busy;
    logic [2:0] result;
    logic       result_valid;
    logic       timeout_err;
    logic [7:0] frames_waited;

    dice_roll_sequencer #(
        .STABLE_FRAMES  (STABLE),
        .TIMEOUT_FRAMES (TMO),
        .REQUIRE_MOTION (1)
    ) dut (
        .pclk          (pclk),
        .reset         (reset),
        .vsync         (vsync),
        .dice_value    (dice_value),
        .start         (start),
        .ack           (ack),
        .busy          (busy),
        .result        (result),
        .result_valid  (result_valid),
        .timeout_err   (timeout_err),
        .frames_waited (frames_waited)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;
    int frm [1:TMO];
    int exp_result = 0;

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: walk the frame list, find the first frame that differs from
    // the arm value (or is blank), then the first frame ending a run of
    // STABLE identical non-blank samples; otherwise the roll times out.
    task automatic model_roll(input int arm, output int kind, output int k, output int res);
        int motion;
        int run;
        int prev;
        int s;
        motion = 0; run = 0; prev = 0;
        kind = 1; k = TMO; res = 0;
        for (int i = 1; i <= TMO; i++) begin
            s = (frm[i] == 7) ? 0 : frm[i];
            if (motion == 0) begin
                if (s != arm || s == 0) begin
                    motion = i;
                    run    = (s != 0) ? 1 : 0;
                    prev   = s;
                end
            end else begin
                if (s == 0)         run = 0;
                else if (s == prev) run = run + 1;
                else                run = 1;
                prev = s;
                if (run == STABLE) begin
                    kind = 0; k = i; res = s;
                    return;
                end
            end
        end
    endtask

    // One frame: vsync high for a cycle with the value presented, then low;
    // the tick lands on the following edge and outputs are sampled a half
    // cycle later. Optional noise pulses start/ack, which must be ignored.
    task automatic frame(input int v, input bit noise);
        dice_value = 3'(v);
        vsync = 1'b1;
        if (noise) begin
            start = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 3) == 0);
        end
        @(negedge pclk);
        vsync = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        @(negedge pclk);
    endtask

    task automatic fill_random(input int from);
        for (int i = from; i <= TMO; i++) begin
            if (i > 1 && $urandom_range(0, 9) < 8) frm[i] = frm[i-1];
            else                                  frm[i] = int'($urandom_range(0, 7));
        end
    endtask

    task automatic run_roll(input int arm, input string name);
        int kind, k, res, sarm;
        dice_value = 3'(arm);
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        check_eq({name, "_arm_busy"}, int'(busy), 1);
        check_eq({name, "_arm_frames"}, int'(frames_waited), 0);
        sarm = (arm == 7) ? 0 : arm;
        model_roll(sarm, kind, k, res);
        for (int i = 1; i <= k; i++) begin
            frame(frm[i], 1'b1);
            if (i < k) begin
                check_eq({name, "_run_valid"}, int'(result_valid), 0);
                check_eq({name, "_run_err"}, int'(timeout_err), 0);
                check_eq({name, "_run_frames"}, int'(frames_waited), i);
            end
        end
        if (kind == 0) exp_result = res;
        check_eq({name, "_end_valid"}, int'(result_valid), (kind == 0) ? 1 : 0);
        check_eq({name, "_end_err"}, int'(timeout_err), (kind == 1) ? 1 : 0);
        check_eq({name, "_end_result"}, int'(result), exp_result);
        check_eq({name, "_end_frames"}, int'(frames_waited), k);
        check_eq({name, "_end_busy"}, int'(busy), 1);
        // A further frame while waiting for ack must change nothing.
        frame(frm[k], 1'b0);
        check_eq({name, "_hold_valid"}, int'(result_valid), (kind == 0) ? 1 : 0);
        check_eq({name, "_hold_frames"}, int'(frames_waited), k);
        // Ack, sometimes together with start (start must be dropped).
        ack   = 1'b1;
        start = ($urandom_range(0, 1) == 1);
        @(negedge pclk);
        ack   = 1'b0;
        start = 1'b0;
        check_eq({name, "_ack_busy"}, int'(busy), 0);
        check_eq({name, "_ack_valid"}, int'(result_valid), 0);
        check_eq({name, "_ack_err"}, int'(timeout_err), 0);
        check_eq({name, "_ack_result"}, int'(result), exp_result);
        $display("roll %s arm=%0d -> %s at frame %0d result=%0d", name, arm,
                 (kind == 0) ? "DONE" : "TIMEOUT", k, exp_result);
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        reset = 1'b0;
        @(negedge pclk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_result", int'(result), 0);
        check_eq("rst_valid", int'(result_valid), 0);
        check_eq("rst_err", int'(timeout_err), 0);
        check_eq("rst_frames", int'(frames_waited), 0);
        $display("reset released, outputs idle");

        // Two blank frames, then eight fives.
        for (int i = 1; i <= TMO; i++) frm[i] = (i <= 2) ? 0 : 5;
        run_roll(3, "blank_then_5");

        // Run of 4 broken by a change to 2.
        for (int i = 1; i <= TMO; i++) frm[i] = (i <= 3) ? 4 : 2;
        run_roll(1, "restart_on_2");

        // Value never moves from the arm value.
        for (int i = 1; i <= TMO; i++) frm[i] = 6;
        run_roll(6, "no_motion");

        // A 7 in the middle of a run clears it.
        for (int i = 1; i <= TMO; i++) frm[i] = 3;
        frm[6] = 7;
        run_roll(1, "seven_clears");

        // Eighth stable frame lands exactly on the timeout frame.
        for (int i = 1; i <= TMO; i++) frm[i] = (i <= TMO - STABLE) ? 0 : 4;
        run_roll(1, "settle_at_timeout");

        // Reset in the middle of settling.
        dice_value = 3'd2;
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        frame(0, 1'b1);
        frame(3, 1'b1);
        frame(3, 1'b1);
        reset = 1'b1;
        @(negedge pclk);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_result", int'(result), 0);
        check_eq("midrst_valid", int'(result_valid), 0);
        check_eq("midrst_err", int'(timeout_err), 0);
        check_eq("midrst_frames", int'(frames_waited), 0);
        reset = 1'b0;
        exp_result = 0;
        @(negedge pclk);
        $display("reset during settle returned to idle");

        for (int r = 0; r < 20; r++) begin
            fill_random(1);
            run_roll(int'($urandom_range(0, 7)), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
